// File: rtl/bcd_display_ctrl.sv
// Load sequencer for the binary-to-BCD converter plus a 4-digit multiplexed
// common-anode 7-segment scanner with leading-zero blanking.
module bcd_display_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] number_in,
  input  logic [2:0]  func_in,
  output logic        busy,
  output logic        overflow,
  output logic [13:0] bcd_number,
  output logic [2:0]  bcd_func,
  input  logic [3:0]  bcd_thuns,
  input  logic [3:0]  bcd_huns,
  input  logic [3:0]  bcd_tens,
  input  logic [3:0]  bcd_ones,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  // state   | meaning
  // IDLE    | waiting for load
  // SETTLE  | converter inputs registered, combinational path settling
  // CAPTURE | converter digits latched into the display register
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [1:0]       state;
  logic [3:0][3:0]  dig;
  logic             disp_blank;
  logic [PW-1:0]    presc;
  logic [1:0]       idx;
  logic [3:0]       cur;
  logic             lz;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      overflow   <= 1'b0;
      bcd_number <= '0;
      bcd_func   <= '0;
      dig        <= '0;
      disp_blank <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            bcd_number <= number_in;
            if (func_in == 3'b000 && number_in > 14'd9999) begin
              bcd_func <= 3'b101;
              overflow <= 1'b1;
            end else begin
              bcd_func <= func_in;
              overflow <= 1'b0;
            end
            state <= S_SETTLE;
          end
        end
        S_SETTLE: state <= S_CAPTURE;
        S_CAPTURE: begin
          // Funcs 110/111 blank the whole display without using the converter
          if (bcd_func[2:1] == 2'b11) begin
            dig        <= '0;
            disp_blank <= 1'b1;
          end else begin
            dig        <= {bcd_thuns, bcd_huns, bcd_tens, bcd_ones};
            disp_blank <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1110;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
      an    <= ~(4'b0001 << (idx + 2'd1));
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign cur = dig[idx];

  always_comb begin
    lz = 1'b0;
    case (idx)
      2'd3: lz = (dig[3] == 4'd0);
      2'd2: lz = (dig[3] == 4'd0) && (dig[2] == 4'd0);
      2'd1: lz = (dig[3] == 4'd0) && (dig[2] == 4'd0) && (dig[1] == 4'd0);
      default: lz = 1'b0;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    if (!(disp_blank || lz)) begin
      case (cur)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with a behavioural model of the
// binary-to-BCD converter driven from the DUT's bcd_number/bcd_func.
module tb_bcd_display_ctrl;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000, G9 = 7'b0010000;
  localparam logic [6:0] GC = 7'b1000110, GE = 7'b0000110, GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] number_in = '0;
  logic [2:0]  func_in = '0;
  logic        busy, overflow;
  logic [13:0] bcd_number;
  logic [2:0]  bcd_func;
  logic [3:0]  bcd_thuns, bcd_huns, bcd_tens, bcd_ones;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad = 0;
  logic [6:0] scan_seg [4];
  bit         scan_ok [4];
  logic [6:0] exp_seg [4];

  always #5 clk = ~clk;

  bcd_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .number_in(number_in), .func_in(func_in),
    .busy(busy), .overflow(overflow), .bcd_number(bcd_number), .bcd_func(bcd_func),
    .bcd_thuns(bcd_thuns), .bcd_huns(bcd_huns), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .an(an), .seg(seg)
  );

  // converter model: error shows as E,F,F over the low three digits
  always_comb begin
    bcd_thuns = 4'd0; bcd_huns = 4'd0; bcd_tens = 4'd0; bcd_ones = 4'd0;
    case (bcd_func)
      3'b000: begin
        bcd_thuns = 4'((int'(bcd_number) / 1000) % 10);
        bcd_huns  = 4'((int'(bcd_number) / 100) % 10);
        bcd_tens  = 4'((int'(bcd_number) / 10) % 10);
        bcd_ones  = 4'(int'(bcd_number) % 10);
      end
      3'b001, 3'b010, 3'b011, 3'b100: bcd_ones = 4'hA + 4'(bcd_func) - 4'd1;
      3'b101: begin bcd_huns = 4'hE; bcd_tens = 4'hF; bcd_ones = 4'hF; end
      default: ;
    endcase
  end

  task automatic do_load(input logic [13:0] n, input logic [2:0] f);
    @(negedge clk);
    load = 1'b1; number_in = n; func_in = f;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic scan_display();
    int n;
    logic [3:0] tgt;
    for (int d = 0; d < 4; d++) begin
      tgt = ~(4'b0001 << d);
      n = 0;
      @(negedge clk);
      while (an !== tgt && n < 20) begin
        @(negedge clk);
        n++;
      end
      scan_ok[d]  = (n < 20);
      scan_seg[d] = seg;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    total++; if (bcd_number !== 14'd0 || bcd_func !== 3'd0)
      begin bad++; $display("FAIL reset_bcd got=%0d/%b want=0/000", bcd_number, bcd_func); end
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b want=1110", an); end
    total++; if (seg !== G0) begin bad++; $display("FAIL reset_seg got=%b want=%b", seg, G0); end
    rst = 1'b0;
    scan_display();
    exp_seg = '{G0, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL reset_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
  endtask

  task automatic test_number();
    do_load(14'd1234, 3'b000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL n1234_busy1 got=%b want=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL n1234_busy2 got=%b want=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL n1234_busy3 got=%b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL n1234_ovf got=%b want=0", overflow); end
    total++; if (bcd_number !== 14'd1234) begin bad++; $display("FAIL n1234_bcdnum got=%0d want=1234", bcd_number); end
    scan_display();
    exp_seg = '{G4, G3, G2, G1};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL n1234_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
  endtask

  task automatic test_blanking();
    do_load(14'd7, 3'b000);
    repeat (2) @(negedge clk);
    scan_display();
    exp_seg = '{G7, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL n7_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
  endtask

  task automatic test_overflow();
    do_load(14'd10000, 3'b000);
    repeat (2) @(negedge clk);
    total++; if (bcd_func !== 3'b101) begin bad++; $display("FAIL ovf_func got=%b want=101", bcd_func); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    scan_display();
    exp_seg = '{GF, GF, GE, BL};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL ovf_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
    do_load(14'd5, 3'b000);
    repeat (2) @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    total++; if (bcd_func !== 3'b000) begin bad++; $display("FAIL ovf_clear_func got=%b want=000", bcd_func); end
    scan_display();
    total++; if (!scan_ok[0] || scan_seg[0] !== G5)
      begin bad++; $display("FAIL ovf_clear_ones got=%b want=%b", scan_seg[0], G5); end
  endtask

  task automatic test_symbol_busy();
    do_load(14'd0, 3'b011);
    // overflow-worthy load held across SETTLE and CAPTURE edges must be dropped
    load = 1'b1; number_in = 14'd12000; func_in = 3'b000;
    repeat (2) @(negedge clk);
    load = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sym_busy got=%b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sym_ovf got=%b want=0", overflow); end
    total++; if (bcd_func !== 3'b011 || bcd_number !== 14'd0)
      begin bad++; $display("FAIL sym_bcd got=%b/%0d want=011/0", bcd_func, bcd_number); end
    scan_display();
    exp_seg = '{GC, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL sym_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
  endtask

  task automatic test_blank_func();
    do_load(14'd8888, 3'b110);
    repeat (2) @(negedge clk);
    scan_display();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== BL)
        begin bad++; $display("FAIL blankf_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], BL, scan_ok[d]); end
    end
  endtask

  task automatic test_reset_in_settle();
    do_load(14'd5678, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL rstmid_an got=%b want=1110", an); end
    total++; if (seg !== G0) begin bad++; $display("FAIL rstmid_seg got=%b want=%b", seg, G0); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (bcd_number !== 14'd0) begin bad++; $display("FAIL rstmid_bcdnum got=%0d want=0", bcd_number); end
    scan_display();
    exp_seg = '{G0, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL rstmid_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
  endtask

  task automatic test_back_to_back();
    do_load(14'd0, 3'b000);
    @(negedge clk);
    do_load(14'd9999, 3'b000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    repeat (2) @(negedge clk);
    total++; if (bcd_number !== 14'd9999) begin bad++; $display("FAIL b2b_bcdnum got=%0d want=9999", bcd_number); end
    scan_display();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== G9)
        begin bad++; $display("FAIL b2b9999_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], G9, scan_ok[d]); end
    end
    do_load(14'd0, 3'b000);
    repeat (2) @(negedge clk);
    scan_display();
    exp_seg = '{G0, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      total++;
      if (!scan_ok[d] || scan_seg[d] !== exp_seg[d])
        begin bad++; $display("FAIL zero_scan d%0d got=%b want=%b ok=%0d", d, scan_seg[d], exp_seg[d], scan_ok[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_number();
    test_blanking();
    test_overflow();
    test_symbol_busy();
    test_blank_func();
    test_reset_in_settle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
